prbs_status_led: RTL
====================

// Module: prbs_status_led
// PURPOSE
//  Downstream consumer of the PRBS bring-up FSM. Watches rx_prbs_mode, prbs_test_pass and rx_prbs_err.
//  Classifies the link as IDLE / SELFTEST / RUN / FAIL, counts post-self-test bit errors (saturating) and drives 4 board LEDs.
//  Sits between the PRBS FSM outputs and the LED pins; no feedback into the FSM.
// PARAMETERS
//  CNT_W           16          width of err_count (saturating)
//  HB_DIV          25_000_000  heartbeat half-period in clk cycles (led[0] toggle)
//  ERR_STRETCH     5_000_000   cycles led[2] stays lit after the last error
//  SELFTEST_TMO    1_200_000_000  cycles allowed in SELFTEST before declaring FAIL (>1e9 inject window)
//  FAIL_DIV        6_250_000   led[3] toggle half-period in FAIL
// PORTS
//  clk             in   1      system clock (same domain as the PRBS FSM)
//  reset_n         in   1      asynchronous active-low reset
//  rx_prbs_mode    in   3      from FSM; PRBS31 (3'b100) means checker enabled
//  prbs_test_pass  in   1      from FSM; high once an injected error has been detected
//  rx_prbs_err     in   1      per-cycle checker error flag
//  err_clear       in   1      single-cycle pulse: zero err_count and sticky flag
//  link_state      out  2      0 IDLE, 1 SELFTEST, 2 RUN, 3 FAIL
//  err_count       out  CNT_W  RUN-state errors, saturates at all-ones
//  err_sticky      out  1      set on first RUN-state error, cleared only by err_clear/reset
//  led             out  4      [0] heartbeat, [1] pass, [2] error activity, [3] fail/sticky
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, all counters 0, err_count=0, err_sticky=0, led=4'b0000.
//  FSM, registered, one transition per clk:
//   IDLE: rx_prbs_mode==3'b100 -> SELFTEST (timeout counter cleared).
//   SELFTEST: prbs_test_pass=1 -> RUN; else timeout counter reaches SELFTEST_TMO-1 -> FAIL.
//   RUN / FAIL: rx_prbs_mode!=3'b100 -> IDLE (any state, highest priority). FAIL exits only this way.
//   Pass and timeout on the same cycle: pass wins (RUN).
//  Errors are counted only while in RUN and rx_prbs_err=1. SELFTEST errors are deliberate injection and are ignored.
//  err_count: +1 per erroring cycle, holds at 2^CNT_W-1. err_clear and a counted error on the same cycle -> result is 1, sticky=1.
//  err_count and err_sticky persist through RUN->IDLE; they are cleared only by err_clear or reset.
//  led[0]: toggles every HB_DIV cycles in all states, including out of reset (liveness).
//  led[1]: 1 iff state==RUN.
//  led[2]: stretched error: goes high the cycle after a counted error, stays high ERR_STRETCH cycles after the most recent one (retriggerable).
//  led[3]: FAIL -> toggles every FAIL_DIV cycles; RUN -> steady err_sticky; else 0.
//  All outputs registered; latency from an input to the state/counter/LED output is 1 clk.
//  Divider counters wrap to 0 at terminal count; no free-running counter wider than needed ($clog2).
// CONFIGURATION
//  PRBS_STATUS_ERR_RATE_EN defined: adds output err_rate[CNT_W-1:0] and parameter RATE_WIN (default 100_000_000).
//   Counts RUN errors per RATE_WIN-cycle window; err_rate is updated with the window total at window end (saturating).
//   The window restarts on entry to RUN. err_rate holds between updates and is 0 after reset.
//  Not defined: no err_rate port, no window logic; all other behaviour is identical.
// STRUCTURE
//  Shared package prbs_pkg: PRBS_MODE_PRBS31=3'b100, link_state encodings (LS_IDLE..LS_FAIL), LED index constants.
//  One sub-module: led_pulse_stretch (param LEN; in pulse -> out high LEN cycles, retriggerable, async active-low reset). Used for led[2].
// TESTING
//  1 reset_n low mid-RUN with err_count=7 -> next cycle link_state=0, err_count=0, led=0000.
//  2 mode=100, pass rises at cycle 50 with 20 error cycles before -> link_state 1 then 2, err_count=0, led[1]=1.
//  3 RUN, 3 error pulses -> err_count=3, err_sticky=1, led[2] high until ERR_STRETCH (test value 8) cycles after the 3rd.
//  4 SELFTEST_TMO=100, pass never arrives -> link_state=3 at cycle 100, led[3] toggles; mode->000 -> IDLE.
//  5 CNT_W=4, 20 RUN errors -> err_count=15 held; err_clear together with an error -> err_count=1.
//  6 PRBS_STATUS_ERR_RATE_EN, RATE_WIN=10, 4 errors in a window -> err_rate=4 at window end, 0 in the next clean window.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS link-status block: PRBS31 mode code, link state
// encodings, LED bit positions and a counter-width helper.
package prbs_pkg;

  localparam logic [2:0] PRBS_MODE_PRBS31 = 3'b100;

  typedef enum logic [1:0] {
    LS_IDLE     = 2'd0,
    LS_SELFTEST = 2'd1,
    LS_RUN      = 2'd2,
    LS_FAIL     = 2'd3
  } link_state_e;

  localparam int LED_HB   = 0;
  localparam int LED_PASS = 1;
  localparam int LED_ERR  = 2;
  localparam int LED_FAIL = 3;

  // Bits needed for a counter holding 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Retriggerable pulse stretcher: a single-cycle pulse drives the output high for
// LEN cycles starting the cycle after the pulse; a new pulse restarts the count.
module led_pulse_stretch
  import prbs_pkg::*;
#(
  parameter int LEN = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pulse,
  output logic out
);

  localparam int W = cnt_w(LEN + 1);

  logic [W-1:0] remain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remain <= '0;
      out    <= 1'b0;
    end else if (pulse) begin
      remain <= W'(LEN);
      out    <= 1'b1;
    end else begin
      if (remain != '0) remain <= remain - 1'b1;
      out <= (remain > W'(1));
    end
  end

endmodule

// File: rtl/prbs_status_led.sv
// Link status classifier and LED driver downstream of the PRBS bring-up FSM.
// Optional macro PRBS_STATUS_ERR_RATE_EN adds the windowed err_rate output.
module prbs_status_led
  import prbs_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int HB_DIV       = 25_000_000,
  parameter int ERR_STRETCH  = 5_000_000,
  parameter int SELFTEST_TMO = 1_200_000_000,
  parameter int FAIL_DIV     = 6_250_000
`ifdef PRBS_STATUS_ERR_RATE_EN
  ,
  parameter int RATE_WIN     = 100_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       rx_prbs_mode,
  input  logic             prbs_test_pass,
  input  logic             rx_prbs_err,
  input  logic             err_clear,
  output logic [1:0]       link_state,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic [3:0]       led
`ifdef PRBS_STATUS_ERR_RATE_EN
  ,
  output logic [CNT_W-1:0] err_rate
`endif
);

  localparam int TMO_W  = cnt_w(SELFTEST_TMO);
  localparam int HB_W   = cnt_w(HB_DIV);
  localparam int FAIL_W = cnt_w(FAIL_DIV);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + 1'b1 : v;
  endfunction

  link_state_e       state, state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [HB_W-1:0]   hb_cnt;
  logic              hb;
  logic [FAIL_W-1:0] fail_cnt, fail_cnt_nxt;
  logic              fail_tgl, fail_tgl_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              sticky_nxt;
  logic              led_pass, led_err, led_fail, led_fail_nxt;
  logic              counted;
  logic              tmo_hit;

  assign counted = (state == LS_RUN) && rx_prbs_err;
  assign tmo_hit = (tmo_cnt == TMO_W'(SELFTEST_TMO - 1));

  always_comb begin
    state_nxt = state;
    if (rx_prbs_mode != PRBS_MODE_PRBS31) begin
      state_nxt = LS_IDLE;
    end else begin
      case (state)
        LS_IDLE:     state_nxt = LS_SELFTEST;
        LS_SELFTEST: begin
          // A pass on the timeout cycle still counts as a pass.
          if (prbs_test_pass)  state_nxt = LS_RUN;
          else if (tmo_hit)    state_nxt = LS_FAIL;
        end
        default:     state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LS_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (state == LS_SELFTEST && state_nxt == LS_SELFTEST) ? tmo_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    cnt_nxt    = err_count;
    sticky_nxt = err_sticky;
    if (err_clear) begin
      cnt_nxt    = '0;
      cnt_nxt[0] = counted;
      sticky_nxt = counted;
    end else if (counted) begin
      cnt_nxt    = sat_add(err_count, 1'b1);
      sticky_nxt = 1'b1;
    end
  end

  always_comb begin
    fail_cnt_nxt = '0;
    fail_tgl_nxt = 1'b0;
    if (state == LS_FAIL) begin
      if (fail_cnt == FAIL_W'(FAIL_DIV - 1)) begin
        fail_tgl_nxt = ~fail_tgl;
      end else begin
        fail_cnt_nxt = fail_cnt + 1'b1;
        fail_tgl_nxt = fail_tgl;
      end
    end
    case (state_nxt)
      LS_FAIL: led_fail_nxt = fail_tgl_nxt;
      LS_RUN:  led_fail_nxt = sticky_nxt;
      default: led_fail_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
      fail_cnt   <= '0;
      fail_tgl   <= 1'b0;
      led_pass   <= 1'b0;
      led_fail   <= 1'b0;
    end else begin
      err_count  <= cnt_nxt;
      err_sticky <= sticky_nxt;
      fail_cnt   <= fail_cnt_nxt;
      fail_tgl   <= fail_tgl_nxt;
      led_pass   <= (state_nxt == LS_RUN);
      led_fail   <= led_fail_nxt;
    end
  end

  // Heartbeat runs unconditionally so a dead clock or stuck reset is visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_W'(HB_DIV - 1)) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  led_pulse_stretch #(.LEN(ERR_STRETCH)) u_err_stretch (
    .clk     (clk),
    .reset_n (reset_n),
    .pulse   (counted),
    .out     (led_err)
  );

  assign link_state     = state;
  assign led[LED_HB]    = hb;
  assign led[LED_PASS]  = led_pass;
  assign led[LED_ERR]   = led_err;
  assign led[LED_FAIL]  = led_fail;

`ifdef PRBS_STATUS_ERR_RATE_EN
  localparam int RW = cnt_w(RATE_WIN);

  logic [RW-1:0]    win_cnt;
  logic [CNT_W-1:0] win_acc;

  // Window phase is anchored to RUN entry; a partial window on RUN exit is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt  <= '0;
      win_acc  <= '0;
      err_rate <= '0;
    end else if (state != LS_RUN) begin
      win_cnt <= '0;
      win_acc <= '0;
    end else if (win_cnt == RW'(RATE_WIN - 1)) begin
      err_rate <= sat_add(win_acc, counted);
      win_cnt  <= '0;
      win_acc  <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      win_acc <= sat_add(win_acc, counted);
    end
  end
`endif

endmodule
